// File: rtl/fact_pkg.sv
// Shared constants and FSM encoding for the factorial controller.
// Optional overflow detection is enabled by defining FACT_OVF_DETECT_EN.
package fact_pkg;
    localparam int          FACT_N_W    = 4;
    localparam int          FACT_DATA_W = 32;
    localparam int unsigned FACT_ONE    = 1;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_RUN  = 2'd2;
    localparam state_t ST_DONE = 2'd3;
endpackage

// File: rtl/fact_ctrl_if.sv
// Bundle of user-side request/result signals and down-counter strobes.
// slave: the controller; master: the user logic plus the counter.
interface fact_ctrl_if
    import fact_pkg::*;
#(
    parameter int N_W    = FACT_N_W,
    parameter int DATA_W = FACT_DATA_W
);
    logic              go;
    logic [N_W-1:0]    n;
    logic [N_W-1:0]    cnt_in;
    logic [N_W-1:0]    cnt_n;
    logic              LD_CNT;
    logic              CNT_EN;
    logic [DATA_W-1:0] product;
    logic              busy;
    logic              done;
    logic              ovf;

    modport slave (
        input  go, n, cnt_in,
        output cnt_n, LD_CNT, CNT_EN, product, busy, done, ovf
    );

    modport master (
        output go, n, cnt_in,
        input  cnt_n, LD_CNT, CNT_EN, product, busy, done, ovf
    );
endinterface

// File: rtl/fact_prod_reg.sv
// Product register: init-to-one, multiply-by-count, optional overflow compare.
// FACT_OVF_DETECT_EN adds the sticky ovf flag and the early-exit indication.
module fact_prod_reg
    import fact_pkg::*;
#(
    parameter int N_W    = FACT_N_W,
    parameter int DATA_W = FACT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_i,
    input  logic              mul_en_i,
    input  logic [N_W-1:0]    cnt_i,
    output logic [DATA_W-1:0] product_o,
    output logic              ovf_o,
    output logic              ovf_now_o
);
    logic [DATA_W-1:0] product_q, product_d;
    logic [DATA_W-1:0] mul_lo;

`ifdef FACT_OVF_DETECT_EN
    logic [DATA_W+N_W-1:0] mul_full;
    logic                  ovf_q, ovf_d;

    assign mul_full  = {{N_W{1'b0}}, product_q} * {{DATA_W{1'b0}}, cnt_i};
    assign mul_lo    = mul_full[DATA_W-1:0];
    assign ovf_now_o = mul_en_i & (|mul_full[DATA_W+N_W-1:DATA_W]);

    always_comb begin
        ovf_d = ovf_q;
        if (init_i)         ovf_d = 1'b0;
        else if (ovf_now_o) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign ovf_o = ovf_q;
`else
    // Without detection the product simply wraps modulo 2^DATA_W.
    assign mul_lo    = product_q * {{(DATA_W-N_W){1'b0}}, cnt_i};
    assign ovf_now_o = 1'b0;
    assign ovf_o     = 1'b0;
`endif

    always_comb begin
        product_d = product_q;
        if (init_i)        product_d = DATA_W'(FACT_ONE);
        else if (mul_en_i) product_d = mul_lo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) product_q <= '0;
        else        product_q <= product_d;
    end

    assign product_o = product_q;
endmodule

// File: rtl/fact_ctrl.sv
// Factorial controller: drives LD_CNT/CNT_EN into a down-counter, accumulates n!.
// Optional overflow early-exit when FACT_OVF_DETECT_EN is defined.
module fact_ctrl
    import fact_pkg::*;
#(
    parameter int N_W    = FACT_N_W,
    parameter int DATA_W = FACT_DATA_W
) (
    input  logic        clk,
    input  logic        rst_n,
    fact_ctrl_if.slave  bus
);
    state_t         state_q, state_d;
    logic [N_W-1:0] cnt_n_q, cnt_n_d;
    logic           mul_en;
    logic           ovf_now;

    // A returned count of 0 or 1 ends the run; 0 is treated like 1.
    assign mul_en = (state_q == ST_RUN) && (bus.cnt_in > N_W'(1));

    always_comb begin
        state_d = state_q;
        cnt_n_d = cnt_n_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.go) begin
                    state_d = ST_LOAD;
                    cnt_n_d = bus.n;
                end
            end
            ST_LOAD: state_d = ST_RUN;
            ST_RUN:  if (!mul_en || ovf_now) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_n_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_n_q <= cnt_n_d;
        end
    end

    fact_prod_reg #(
        .N_W    (N_W),
        .DATA_W (DATA_W)
    ) u_prod (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_i    (state_q == ST_LOAD),
        .mul_en_i  (mul_en),
        .cnt_i     (bus.cnt_in),
        .product_o (bus.product),
        .ovf_o     (bus.ovf),
        .ovf_now_o (ovf_now)
    );

    assign bus.cnt_n  = cnt_n_q;
    assign bus.LD_CNT = (state_q == ST_LOAD);
    assign bus.CNT_EN = mul_en;
    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.done   = (state_q == ST_DONE);
endmodule

// File: tb/tb_fact_ctrl.sv
// Directed bench for fact_ctrl with a behavioural down-counter attached.
// Expectations for n=13 follow FACT_OVF_DETECT_EN when it is defined.
module tb_fact_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    fact_ctrl_if bus ();

    fact_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          cnt_q <= 4'd0;
        else if (bus.LD_CNT) cnt_q <= bus.cnt_n;
        else if (bus.CNT_EN) cnt_q <= cnt_q - 4'd1;
    end
    assign bus.cnt_in = cnt_q;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // k counts cycles after the go-accept cycle T, sampled on falling edges.
    task automatic run_op(input logic [3:0] n_v, input logic [31:0] exp_p, input int exp_done,
                          input int exp_en, input logic exp_ovf, input int inj_k, input string tag);
        int done_k, ld_k, ld_cnt, en_first, en_cnt, both, busy_lo;
        done_k = 0; ld_k = 0; ld_cnt = 0; en_first = 0; en_cnt = 0; both = 0; busy_lo = 0;
        @(negedge clk);
        bus.go = 1'b1;
        bus.n  = n_v;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.LD_CNT) begin ld_cnt++; if (ld_k == 0) ld_k = k; end
            if (bus.CNT_EN) begin en_cnt++; if (en_first == 0) en_first = k; end
            if (bus.LD_CNT && bus.CNT_EN) both++;
            if (!bus.busy) busy_lo++;
            if (k == 1) begin bus.go = 1'b0; bus.n = ~n_v; end
            if (k == inj_k) begin bus.go = 1'b1; bus.n = 4'd3; end
            else if (inj_k > 0 && k == inj_k + 1) bus.go = 1'b0;
            if (bus.done) begin done_k = k; break; end
        end
        chk({tag, "_ld_k"},     64'(ld_k), 64'd1);
        chk({tag, "_ld_cnt"},   64'(ld_cnt), 64'd1);
        chk({tag, "_done_k"},   64'(done_k), 64'(exp_done));
        chk({tag, "_en_cnt"},   64'(en_cnt), 64'(exp_en));
        chk({tag, "_en_first"}, 64'(en_first), (exp_en > 0) ? 64'd2 : 64'd0);
        chk({tag, "_both"},     64'(both), 64'd0);
        chk({tag, "_busy_lo"},  64'(busy_lo), 64'd0);
        chk({tag, "_cnt_n"},    64'(bus.cnt_n), 64'(n_v));
        chk({tag, "_product"},  64'(bus.product), 64'(exp_p));
        chk({tag, "_ovf"},      64'(bus.ovf), 64'(exp_ovf));
        @(negedge clk);
        chk({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_idle_done"}, 64'(bus.done), 64'd0);
        chk({tag, "_hold_prod"}, 64'(bus.product), 64'(exp_p));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.go   = 1'b0;
        bus.n    = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_product", 64'(bus.product), 64'd0);
        chk("rst_cnt_n",   64'(bus.cnt_n), 64'd0);
        chk("rst_ld",      64'(bus.LD_CNT), 64'd0);
        chk("rst_en",      64'(bus.CNT_EN), 64'd0);
        chk("rst_busy",    64'(bus.busy), 64'd0);
        chk("rst_done",    64'(bus.done), 64'd0);
        chk("rst_ovf",     64'(bus.ovf), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(4'd5,  32'd120,       7,  4,  1'b0, 0, "n5");
        run_op(4'd0,  32'd1,         3,  0,  1'b0, 0, "n0");
        run_op(4'd1,  32'd1,         3,  0,  1'b0, 0, "n1");
        run_op(4'd12, 32'd479001600, 14, 11, 1'b0, 0, "n12");
`ifdef FACT_OVF_DETECT_EN
        run_op(4'd13, 32'd1932053504, 14, 12, 1'b1, 0, "n13");
`else
        run_op(4'd13, 32'd1932053504, 15, 12, 1'b0, 0, "n13");
`endif
        run_op(4'd6,  32'd720,       8,  5,  1'b0, 4, "n6_inject");
        run_op(4'd3,  32'd6,         5,  2,  1'b0, 0, "n3");

        // go held high: n=2 finishes at k=4, IDLE at k=5 re-accepts, LOAD at k=6.
        @(negedge clk);
        bus.go = 1'b1;
        bus.n  = 4'd2;
        repeat (4) @(negedge clk);
        chk("hold_done", 64'(bus.done), 64'd1);
        chk("hold_prod", 64'(bus.product), 64'd2);
        @(negedge clk);
        chk("hold_idle", 64'(bus.busy), 64'd0);
        @(negedge clk);
        chk("hold_reload", 64'(bus.LD_CNT), 64'd1);
        bus.go = 1'b0;
        repeat (6) @(negedge clk);
        chk("hold_drain", 64'(bus.busy), 64'd0);

        // Asynchronous reset in the middle of an n=9 run.
        @(negedge clk);
        bus.go = 1'b1;
        bus.n  = 4'd9;
        @(negedge clk);
        bus.go = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy", 64'(bus.busy), 64'd1);
        chk("mid_en",   64'(bus.CNT_EN), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_product", 64'(bus.product), 64'd0);
        chk("arst_cnt_n",   64'(bus.cnt_n), 64'd0);
        chk("arst_ld",      64'(bus.LD_CNT), 64'd0);
        chk("arst_en",      64'(bus.CNT_EN), 64'd0);
        chk("arst_busy",    64'(bus.busy), 64'd0);
        chk("arst_done",    64'(bus.done), 64'd0);
        chk("arst_ovf",     64'(bus.ovf), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 64'(bus.busy), 64'd0);
        run_op(4'd4, 32'd24, 6, 3, 1'b0, 0, "n4_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fact_ctrl.md
Name: fact_ctrl

Overview:
- Control-and-accumulate end of the factorial calculator's counter interface.
- Accepts a start request and operand n, drives LD_CNT/CNT_EN into the factorial down-counter, and consumes the returned count.
- Multiplies each returned count into a product register and reports n! with a done pulse.
- Sits between the top-level user interface (switches/buttons) and the CNT-style down-counter.

Parameters:
- N_W, 4, width of operand n and of the count returned by the counter.
- DATA_W, 32, width of the product register.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- go  input  1  start request, sampled only in IDLE.
- n  input  N_W  operand; captured on the cycle go is accepted.
- cnt_in  input  N_W  count returned by the down-counter; registered on its side, valid the cycle after LD_CNT or CNT_EN.
- cnt_n  output  N_W  captured operand presented to the counter's load input.
- LD_CNT  output  1  load strobe to the counter.
- CNT_EN  output  1  decrement strobe to the counter.
- product  output  DATA_W  accumulated result.
- busy  output  1  high from LOAD through DONE inclusive.
- done  output  1  one-cycle completion pulse.
- ovf  output  1  overflow flag (see Optional Feature).

Behaviour:
- Reset (async, any state, mid-operation included): state=IDLE; product, cnt_n=0; LD_CNT, CNT_EN, busy, done, ovf=0. Takes effect immediately; no partial result survives.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE
  - go=1 -> LOAD; cnt_n<=n.
  - go=0 -> stay.
- LOAD (1 cycle)
  - LD_CNT=1.
  - product<=1; ovf<=0.
  - -> RUN.
- RUN
  - cnt_in<=1: no multiply; CNT_EN=0; -> DONE.
  - Otherwise: product<=product*cnt_in (full DATA_W+N_W product, low DATA_W bits kept); CNT_EN=1; stay in RUN.
- DONE (1 cycle)
  - done=1.
  - -> IDLE.
  - product and ovf hold until the next LOAD.
- Timing, with go accepted in IDLE at cycle T:
  - LOAD at T+1.
  - First RUN at T+2.
  - done high at T+n+2 for n>=2, and at T+3 for n=0 or 1.
- Strobes: LD_CNT and CNT_EN are Moore/decoded outputs. They are never high in the same cycle and never high outside LOAD/RUN.
- go while busy is ignored, not queued. go held high continuously restarts on the cycle after DONE, since IDLE samples it again.
- n changing after capture has no effect until the next accepted go.
- Boundaries:
  - n=0 and n=1 both yield product=1.
  - n=15 is the maximum operand; 15! overflows at DATA_W=32.
  - cnt_in is trusted as monotonically decreasing. An unexpected cnt_in=0 in RUN terminates like 1.

Optional Feature:
- Macro: FACT_OVF_DETECT_EN.
- Defined:
  - In RUN, if the upper N_W bits of the full-width product are nonzero, ovf<=1 (sticky until next LOAD) and the FSM goes straight to DONE. product holds the truncated value from that cycle.
  - done timing for an overflowing n is then earlier than T+n+2.
- Undefined:
  - ovf is tied to 0.
  - The product wraps modulo 2^DATA_W and the run always completes at the nominal latency.

Decomposition:
- Shared package fact_pkg:
  - state enum (IDLE/LOAD/RUN/DONE).
  - default N_W and DATA_W constants.
  - constant FACT_ONE = 1 for product initialisation.
- One natural sub-module, fact_prod_reg: product register with init-to-one, multiply-by-count, and overflow compare. The FSM stays in fact_ctrl.

Test Plan:
- Reset, then go with n=5, bench counter model attached -> LD_CNT pulse at T+1; CNT_EN high T+2..T+5; done at T+7; product=120; ovf=0.
- n=0, then n=1 -> done at T+3; product=1; CNT_EN never asserted.
- n=12 -> product=479001600; done at T+14; ovf=0.
- n=13 with FACT_OVF_DETECT_EN -> ovf=1, early done, busy drops after DONE. Without the macro -> product=6227020800 mod 2^32=1932053504, done at T+15, ovf=0.
- go pulsed with n=3 mid-run of n=6 -> ignored; result 720; then a fresh go with n=3 -> 6.
- rst_n asserted during RUN of n=9 -> all outputs 0 asynchronously. After release, go with n=4 -> product=24, correct latency.
